uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  - 8N1/8N2 UART transmitter; companion to the serial debug unit's receiver. Same clk domain (100 MHz), same ready/valid style.
//  - Accepts one byte per handshake from the debug core, serialises it LSB-first on txd, and signals frame completion.
// PARAMETERS
//  - CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); legal range 2..65535
//  - STOP_BITS     1    number of stop bits; legal values 1 or 2
// PORTS
//  - clk     in   1  system clock, 100 MHz
//  - rst     in   1  reset: synchronous, active-high
//  - d_tx    in   8  byte to send; sampled only on an accepting edge
//  - vld_tx  in   1  1 = d_tx holds a byte for transmission
//  - rdy_tx  out  1  1 = idle, able to accept; transfer happens on an edge where vld_tx && rdy_tx
//  - txd     out  1  serial line, idle high; registered output
//  - done_tx out  1  one-cycle pulse in the cycle where the line returns to IDLE after the last stop bit
// BEHAVIOUR
//  - Reset (rst=1 on an edge): state=IDLE, txd=1, rdy_tx=1, done_tx=0, bit/baud counters=0, shift reg=0.
//  - States: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP(STOP_BITS) -> IDLE.
//  - Accept edge T (IDLE, vld_tx=1): d_tx latched into shift reg. Baud counter cleared. From T+1: state=START, txd=0, rdy_tx=0.
//  - Each bit holds txd stable for exactly CLKS_PER_BIT cycles. Baud counter counts 0..CLKS_PER_BIT-1 and wraps; bit advance happens on the wrap.
//  - DATA: d_tx[0] is sent first. Shift right one place per bit. Bit counter 0..7.
//  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. Then state=IDLE, rdy_tx=1, and done_tx=1 in that same cycle.
//  - rdy_tx is low for exactly N*CLKS_PER_BIT cycles per frame. N = 1 + 8 + P + STOP_BITS; P=1 if parity is compiled in, else 0.
//  - Back-to-back: if vld_tx=1 in the first IDLE cycle, that edge accepts. Next start bit follows with no extra idle bit.
//  - vld_tx while rdy_tx=0: ignored; d_tx changes mid-frame do not affect the line. Upstream must hold vld_tx.
//  - rst mid-frame: frame aborted; txd=1 on the next edge; no done_tx pulse.
//  - done_tx and an accept may occur in the same cycle.
//  - No combinational path from any input to txd.
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA.
//    - txd = even parity, i.e. ^latched byte, held for CLKS_PER_BIT cycles.
//    - N grows by 1.
//  - Macro undefined: no PARITY state, no parity logic; DATA goes straight to STOP.
// STRUCTURE
//  - Shared package uart_pkg:
//    - state encoding typedef (IDLE, START, DATA, PARITY, STOP).
//    - DATA_BITS=8 constant.
//    - IDLE_LEVEL=1'b1 constant.
//    - helper to compute CLKS_PER_BIT from clock and baud rate.
//  - One sub-module: uart_baud_tick.
//    - Counter with a synchronous clear input.
//    - Emits a bit_end pulse on the last cycle of each bit period.
//  - Top level holds the FSM, shift register, bit counter and output registers.
// TESTING (bench uses CLKS_PER_BIT=16, STOP_BITS=1 unless noted)
//  - Reset: hold rst 3 cycles -> txd=1, rdy_tx=1, done_tx=0. Release with vld_tx=0 -> outputs unchanged for 100 cycles.
//  - Single byte 8'hA5 -> txd low for 16 cycles from T+1.
//    - Then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high.
//    - rdy_tx low exactly 160 cycles. done_tx one pulse.
//  - Back-to-back 8'h00 then 8'hFF, vld_tx held -> second start bit begins right after first stop bit.
//    - Bench receiver model decodes both bytes.
//  - Busy ignore: change d_tx to 8'h3C mid-frame of 8'h81 -> line carries 8'h81 only.
//  - Reset at cycle 70 of a frame -> txd=1 next edge, rdy_tx=1, no done_tx.
//    - A new byte 8'h5A then sends cleanly.
//  - UART_TX_PARITY_EN, STOP_BITS=2, byte 8'h07 -> parity bit 1. rdy_tx low 12*16=192 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, frame
// constants and a helper that derives the bit period from clock and baud rate.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Rounded clk cycles per bit, e.g. calc_clks_per_bit(100_000_000, 115_200) = 868.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled and flags the last cycle of each bit period on bit_end.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign bit_end = en && (cnt_q == LAST_CNT);

    // Next count: wrap at the end of each bit, restart on a new frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || bit_end) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with ready/valid byte input, LSB-first serial
// output on txd and a one-cycle done_tx pulse at the end of each frame.
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | line high, rdy_tx=1, waiting for vld_tx
// START   | start bit (txd=0) for one bit period
// DATA    | eight data bits, LSB first, shift register moves right
// PARITY  | even parity of the latched byte (only with parity build)
// STOP    | STOP_BITS bit periods of txd=1, then back to IDLE
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_tx,
    input  logic       vld_tx,
    output logic       rdy_tx,
    output logic       txd,
    output logic       done_tx
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic        txd_q, txd_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic accept;
    logic bit_end;

    assign accept  = rdy_q && vld_tx;
    assign rdy_tx  = rdy_q;
    assign txd     = txd_q;
    assign done_tx = done_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state_q != ST_IDLE),
        .bit_end(bit_end)
    );

    // Next-state and next-output logic; every output is taken from a flop.
    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        rdy_d     = rdy_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    txd_d     = 1'b0;
                    rdy_d     = 1'b0;
                    shift_d   = d_tx;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^d_tx;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
                        txd_d     = par_q;
`else
                        state_d   = ST_STOP;
                        txd_d     = IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    txd_d     = IDLE_LEVEL;
                    bit_cnt_d = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        state_d   = ST_IDLE;
                        rdy_d     = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                txd_d     = IDLE_LEVEL;
                rdy_d     = 1'b1;
                bit_cnt_d = '0;
            end
        endcase
    end

    // FSM, shift register, bit counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            txd_q     <= IDLE_LEVEL;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
